// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display driver:
// FSM encoding, active-low segment patterns and per-digit anode codes.
package seg7_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SUB100 = 2'd1,
    S_SUB10  = 2'd2
  } state_e;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] AN_ONES = 3'b110;
  localparam logic [2:0] AN_TENS = 3'b101;
  localparam logic [2:0] AN_HUND = 3'b011;
  localparam logic [2:0] AN_OFF  = 3'b111;

endpackage

// File: rtl/seg7_display_driver_if.sv
// Valid/ready input channel carrying the 8-bit value to be displayed.
interface seg7_display_driver_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low segment decoder with blank override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_display_driver.sv
// Binary-to-BCD by repeated subtraction feeding a free-running 3-digit
// multiplexed common-anode display with leading-zero blanking.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  seg7_display_driver_if.slave    in_if,
  output logic                    out_done,
  output logic [6:0]              seg,
  output logic [2:0]              an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_e        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [1:0]    hund_q, hund_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    disp_h_q, disp_h_d, disp_t_q, disp_t_d, disp_o_q, disp_o_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic          cnt_wrap;

  assign in_if.in_ready = (state_q == S_IDLE);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    hund_d   = hund_q;
    tens_d   = tens_q;
    disp_h_d = disp_h_q;
    disp_t_d = disp_t_q;
    disp_o_d = disp_o_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: if (in_if.in_valid) begin
        rem_d   = in_if.in_data;
        hund_d  = 2'd0;
        tens_d  = 4'd0;
        state_d = S_SUB100;
      end
      S_SUB100: if (rem_q >= 8'd100) begin
        rem_d  = rem_q - 8'd100;
        hund_d = hund_q + 2'd1;
      end else begin
        state_d = S_SUB10;
      end
      S_SUB10: if (rem_q >= 8'd10) begin
        rem_d  = rem_q - 8'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        // remainder is now < 10, so the low nibble is the ones digit
        disp_h_d = {2'b00, hund_q};
        disp_t_d = tens_q;
        disp_o_d = rem_q[3:0];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan timing is independent of the converter; it only reads disp_*.
  assign cnt_wrap = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_wrap) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
  end

  always_comb begin
    cur_digit = disp_o_q;
    cur_blank = 1'b1;
    an_d      = AN_OFF;
    case (idx_q)
      2'd0: begin
        cur_digit = disp_o_q;
        cur_blank = 1'b0;
        an_d      = AN_ONES;
      end
      2'd1: begin
        cur_digit = disp_t_q;
        cur_blank = (disp_h_q == 4'd0) && (disp_t_q == 4'd0);
        an_d      = AN_TENS;
      end
      2'd2: begin
        cur_digit = disp_h_q;
        cur_blank = (disp_h_q == 4'd0);
        an_d      = AN_HUND;
      end
      default: ;
    endcase
  end

  seg7_decode u_decode (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (seg_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      hund_q   <= '0;
      tens_q   <= '0;
      disp_h_q <= '0;
      disp_t_q <= '0;
      disp_o_q <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= AN_OFF;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      hund_q   <= hund_d;
      tens_q   <= tens_d;
      disp_h_q <= disp_h_d;
      disp_t_q <= disp_t_d;
      disp_o_q <= disp_o_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign out_done = done_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed bench for seg7_display_driver: per-cycle comparison against a
// decimal-arithmetic display model plus hand-computed latency/digit checks.
module tb_seg7_display_driver;

  localparam int SD = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       out_done;
  logic [6:0] seg;
  logic [2:0] an;

  seg7_display_driver_if u_if ();

  seg7_display_driver #(.SCAN_DIV(SD)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_if    (u_if),
    .out_done (out_done),
    .seg      (seg),
    .an       (an)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [6:0] segt [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // pos 0 = ones, 1 = tens, 2 = hundreds of value v
  function automatic logic [6:0] seg_of(input int v, input int pos);
    int d;
    bit blank;
    d     = (pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100;
    blank = (pos == 2 && v < 100) || (pos == 1 && v < 10);
    return blank ? 7'h7F : segt[d];
  endfunction

  // Model: outputs after edge n reflect state before edge n.
  int         m_n, m_shown, m_pend, m_left;
  bit         m_busy;
  logic [6:0] exp_seg;
  logic [2:0] exp_an;
  logic       exp_done, exp_ready;

  task automatic m_reset();
    m_n = 0; m_shown = 0; m_pend = 0; m_left = 0; m_busy = 0;
    exp_seg = 7'h7F; exp_an = 3'b111; exp_done = 0; exp_ready = 1;
  endtask

  initial begin
    int idx, v;
    m_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) m_reset();
      else begin
        m_n++;
        idx      = ((m_n - 1) / SD) % 3;
        exp_an   = (idx == 0) ? 3'b110 : (idx == 1) ? 3'b101 : 3'b011;
        exp_seg  = seg_of(m_shown, idx);
        exp_done = 0;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_shown  = m_pend;
            m_busy   = 0;
            exp_done = 1;
          end
        end else if (u_if.in_valid) begin
          v      = int'(u_if.in_data);
          m_pend = v;
          m_busy = 1;
          m_left = v / 100 + (v % 100) / 10 + 2;
        end
        exp_ready = !m_busy;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (!reset_n) begin
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 3'b111);
        chk("rst_done", out_done, 1'b0);
        chk("rst_ready", u_if.in_ready, 1'b1);
      end else begin
        chk("cyc_seg", seg, exp_seg);
        chk("cyc_an", an, exp_an);
        chk("cyc_done", out_done, exp_done);
        chk("cyc_ready", u_if.in_ready, exp_ready);
      end
    end
  end

  task automatic xfer(input int v, output int lat);
    @(negedge clock);
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'(v);
    chk("ready_pre_xfer", u_if.in_ready, 1'b1);
    @(posedge clock);
    #1;
    u_if.in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (out_done) break;
    end
  endtask

  task automatic scan(output logic [6:0] s0, output logic [6:0] s1, output logic [6:0] s2);
    s0 = 'x; s1 = 'x; s2 = 'x;
    for (int i = 0; i < 3 * SD; i++) begin
      @(posedge clock);
      #1;
      case (an)
        3'b110:  s0 = seg;
        3'b101:  s1 = seg;
        3'b011:  s2 = seg;
        default: ;
      endcase
    end
  endtask

  task automatic digits(input string nm, input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
    logic [6:0] s0, s1, s2;
    scan(s0, s1, s2);
    chk({nm, "_ones"}, s0, e0);
    chk({nm, "_tens"}, s1, e1);
    chk({nm, "_hund"}, s2, e2);
  endtask

  initial begin
    int lat, low;
    bit saw_done;
    reset_n       = 1'b1;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'd0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_an", an, 3'b111);
    chk("reset_seg", seg, 7'b1111111);
    chk("reset_ready", u_if.in_ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("first_an", an, 3'b110);
    chk("first_seg", seg, 7'b1000000);

    xfer(0, lat);
    chk("lat_0", lat, 2);
    digits("v0", 7'b1000000, 7'b1111111, 7'b1111111);

    xfer(255, lat);
    chk("lat_255", lat, 9);
    digits("v255", 7'b0010010, 7'b0010010, 7'b0100100);

    xfer(7, lat);
    chk("lat_7", lat, 2);
    digits("v7", 7'b1111000, 7'b1111111, 7'b1111111);

    xfer(40, lat);
    chk("lat_40", lat, 6);
    digits("v40", 7'b1000000, 7'b0011001, 7'b1111111);

    // in_valid held high across two values
    @(negedge clock);
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'd100;
    @(posedge clock);
    #1;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      if (u_if.in_ready) break;
      low++;
      @(posedge clock);
      #1;
    end
    chk("b2b_ready_low", low, 3);
    chk("b2b_done_with_ready", out_done, 1'b1);
    u_if.in_data = 8'd23;
    @(posedge clock);
    #1;
    chk("b2b_accept_23", u_if.in_ready, 1'b0);
    u_if.in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (out_done) break;
    end
    chk("lat_23", lat, 4);
    digits("v23", 7'b0110000, 7'b0100100, 7'b1111111);

    // abort 199 while in SUB10
    @(negedge clock);
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'd199;
    @(posedge clock);
    #1;
    u_if.in_valid = 1'b0;
    saw_done = 0;
    repeat (4) begin
      @(posedge clock);
      #1;
      saw_done |= out_done;
    end
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      saw_done |= out_done;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (12) begin
      @(posedge clock);
      #1;
      saw_done |= out_done;
    end
    chk("abort_no_done", saw_done, 1'b0);
    digits("abort", 7'b1000000, 7'b1111111, 7'b1111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
